// File: rtl/wb_imem_pkg.sv
// Shared types and constants for the Wishbone instruction-memory responder.
// Holds the response-pipeline tag layout and the clog2 helper.
package wb_imem_pkg;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 4;

    typedef struct packed {
        logic valid;
        logic err;
        logic we;
    } rsp_tag_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/wb_imem_ram.sv
// Single-port synchronous RAM, 2^MEMW x 32, registered read, per-byte write (IMEM_WRITE_EN).
// Latency: read data valid the cycle after rd_en; writes land at the same edge.
// Backpressure: none, one access per clock.
module wb_imem_ram #(
    parameter int MEMW = 12
) (
    input  logic            i_clk,
    input  logic            rd_en,
`ifdef IMEM_WRITE_EN
    input  logic [3:0]      wr_be,
    input  logic [31:0]     wr_data,
`endif
    input  logic [MEMW-1:0] addr,
    output logic [31:0]     rd_data
);

    logic [31:0] mem [2**MEMW];

    always_ff @(posedge i_clk) begin
        if (rd_en) begin
            rd_data <= mem[addr];
        end
`ifdef IMEM_WRITE_EN
        for (int b = 0; b < 4; b++) begin
            if (wr_be[b]) begin
                mem[addr][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
`endif
    end

endmodule

// File: rtl/wb_imem_slave.sv
// Pipelined Wishbone responder over on-chip RAM; writes only when IMEM_WRITE_EN is defined.
// Latency: every accepted request gets one ack/err exactly LAT cycles after acceptance, in order.
// Backpressure: o_wb_stall while MAXOUT requests are outstanding and none retires; CYC low aborts all.
module wb_imem_slave
    import wb_imem_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter int                       MEMW          = 12,
    parameter logic [ADDRESS_WIDTH-1:0] BASE          = 'h0001_0000,
    parameter int                       LAT           = 2,
    parameter int                       MAXOUT        = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_wb_cyc,
    input  logic                     i_wb_stb,
    input  logic                     i_wb_we,
    input  logic [ADDRESS_WIDTH-1:0] i_wb_addr,
    input  logic [31:0]              i_wb_data,
    input  logic [3:0]               i_wb_sel,
    output logic                     o_wb_stall,
    output logic                     o_wb_ack,
    output logic                     o_wb_err,
    output logic [31:0]              o_wb_data
);

    localparam int CW = clog2(MAXOUT + 1);

    if (LAT < LAT_MIN || LAT > LAT_MAX || MAXOUT < 1 || MAXOUT > LAT) begin : g_param_err
        $error("wb_imem_slave: LAT must be 1..4 and MAXOUT 1..LAT");
    end

    rsp_tag_t      tag_q [LAT];
    rsp_tag_t      tag_in;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [31:0]   dat_hold_q;
    logic [31:0]   ram_rdata;
    logic [31:0]   rsp_rdata;
    logic          accept;
    logic          in_range;
    logic          req_err;
    logic          rsp_vld;
    logic          ram_rd_en;

    assign in_range  = (i_wb_addr[ADDRESS_WIDTH-1:MEMW] == BASE[ADDRESS_WIDTH-1:MEMW]);
    assign accept    = i_wb_cyc && i_wb_stb && !o_wb_stall;
    assign ram_rd_en = accept && !i_wb_we && in_range;

`ifdef IMEM_WRITE_EN
    logic [3:0] ram_wr_be;
    assign req_err   = !in_range;
    assign ram_wr_be = {4{accept && i_wb_we && in_range}} & i_wb_sel;
`else
    // Read-only build: writes are answered with err and never reach the RAM.
    logic unused_wr;
    assign req_err   = !in_range || i_wb_we;
    assign unused_wr = ^{i_wb_sel, i_wb_data};
`endif

    wb_imem_ram #(.MEMW(MEMW)) u_ram (
        .i_clk   (i_clk),
        .rd_en   (ram_rd_en),
`ifdef IMEM_WRITE_EN
        .wr_be   (ram_wr_be),
        .wr_data (i_wb_data),
`endif
        .addr    (i_wb_addr[MEMW-1:0]),
        .rd_data (ram_rdata)
    );

    assign rsp_vld    = tag_q[LAT-1].valid;
    assign o_wb_ack   = rsp_vld && !tag_q[LAT-1].err;
    assign o_wb_err   = rsp_vld && tag_q[LAT-1].err;
    assign o_wb_stall = (cnt_q == CW'(MAXOUT)) && !rsp_vld;
    assign o_wb_data  = (o_wb_ack && !tag_q[LAT-1].we) ? rsp_rdata : dat_hold_q;

    always_comb begin
        tag_in = '0;
        if (accept) begin
            tag_in.valid = 1'b1;
            tag_in.err   = req_err;
            tag_in.we    = i_wb_we;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!i_wb_cyc) begin
            cnt_d = '0;
        end else if (accept && !rsp_vld) begin
            cnt_d = cnt_q + 1'b1;
        end else if (!accept && rsp_vld) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < LAT; i++) begin
                tag_q[i] <= '0;
            end
            cnt_q      <= '0;
            dat_hold_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            dat_hold_q <= o_wb_data;
            if (!i_wb_cyc) begin
                for (int i = 0; i < LAT; i++) begin
                    tag_q[i] <= '0;
                end
            end else begin
                tag_q[0] <= tag_in;
                for (int i = 1; i < LAT; i++) begin
                    tag_q[i] <= tag_q[i-1];
                end
            end
        end
    end

    // RAM output is the first data stage; later stages just follow the tags.
    if (LAT == 1) begin : g_lat1
        assign rsp_rdata = ram_rdata;
    end else begin : g_latn
        logic [31:0] dat_q [LAT-1];
        always_ff @(posedge i_clk) begin
            dat_q[0] <= ram_rdata;
            for (int i = 1; i < LAT - 1; i++) begin
                dat_q[i] <= dat_q[i-1];
            end
        end
        assign rsp_rdata = dat_q[LAT-2];
    end

endmodule

// File: tb/tb_wb_imem_slave.sv
// Directed bench for wb_imem_slave: vector table of single transactions plus
// burst, throttle, abort, write-then-read and mid-burst reset sequences.
module tb_wb_imem_slave;

    localparam logic [31:0] A_BASE = 32'h0001_0000;
`ifdef IMEM_WRITE_EN
    localparam logic WR_EN = 1'b1;
`else
    localparam logic WR_EN = 1'b0;
`endif

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        logic        exp_ack;
        logic        exp_err;
        logic [31:0] exp_dat;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        cyc;
    logic        stb;
    logic        stb_t;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic [3:0]  sel;
    logic        stall, ack, err;
    logic [31:0] rdat;
    logic        stall_t, ack_t, err_t;
    logic [31:0] rdat_t;

    int          n_chk;
    int          n_err;
    vec_t        vecs [14];
    logic [15:0] ack_pat, err_pat, stall_pat, acc_pat;
    logic [31:0] cap_dat [16];
    logic [31:0] bw_exp;
    logic [31:0] fw_exp;
    logic        acc;
    int          na;

    wb_imem_slave #(.LAT(2), .MAXOUT(2)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_wb_cyc   (cyc),
        .i_wb_stb   (stb),
        .i_wb_we    (we),
        .i_wb_addr  (addr),
        .i_wb_data  (wdat),
        .i_wb_sel   (sel),
        .o_wb_stall (stall),
        .o_wb_ack   (ack),
        .o_wb_err   (err),
        .o_wb_data  (rdat)
    );

    wb_imem_slave #(.LAT(2), .MAXOUT(1)) dut_t (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_wb_cyc   (cyc),
        .i_wb_stb   (stb_t),
        .i_wb_we    (we),
        .i_wb_addr  (addr),
        .i_wb_data  (wdat),
        .i_wb_sel   (sel),
        .o_wb_stall (stall_t),
        .o_wb_ack   (ack_t),
        .o_wb_err   (err_t),
        .o_wb_data  (rdat_t)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, want);
        end
    endtask

    // One request, then watch four cycles: exactly one response, in cycle LAT.
    task automatic run_vec(input vec_t v, input string tag);
        int          n_rsp;
        int          at;
        logic        g_ack;
        logic        g_err;
        logic [31:0] g_dat;
        n_rsp = 0; at = 0; g_ack = 1'b0; g_err = 1'b0; g_dat = '0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = v.we; addr = v.addr; wdat = v.wdata; sel = v.sel;
        @(negedge clk);
        chk({tag, " stall"}, 32'(stall), 32'd0);
        @(posedge clk); #1;
        stb = 1'b0; we = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            if (ack || err) begin
                n_rsp++; at = k; g_ack = ack; g_err = err; g_dat = rdat;
            end
        end
        chk({tag, " rsp_count"}, 32'(n_rsp), 32'd1);
        chk({tag, " rsp_cycle"}, 32'(at), 32'd2);
        chk({tag, " ack"}, 32'(g_ack), 32'(v.exp_ack));
        chk({tag, " err"}, 32'(g_err), 32'(v.exp_err));
        chk({tag, " data"}, g_dat, v.exp_dat);
    endtask

    initial begin
        n_chk = 0; n_err = 0;
        rst_n = 1'b0; cyc = 1'b0; stb = 1'b0; stb_t = 1'b0; we = 1'b0;
        addr = '0; wdat = '0; sel = '0;

        dut.u_ram.mem[12'h005] <= 32'hDEADBEEF;
        dut.u_ram.mem[12'h020] <= 32'hAAAAAAAA;
        dut.u_ram.mem[12'h030] <= 32'h12345678;
        dut.u_ram.mem[12'h040] <= 32'h40404040;
        dut.u_ram.mem[12'h050] <= 32'h50505050;
        dut.u_ram.mem[12'hFFF] <= 32'hCAFEF00D;
        for (int i = 0; i < 8; i++) begin
            dut.u_ram.mem[16 + i]   <= 32'hB000_0000 + 32'(i);
            dut_t.u_ram.mem[16 + i] <= 32'hB000_0000 + 32'(i);
        end

        bw_exp = WR_EN ? 32'hAA22AA44 : 32'hAAAAAAAA;
        fw_exp = WR_EN ? 32'h0BADF00D : 32'h40404040;
        //            we    addr          wdata         sel     ack     err     held/read data
        vecs[0]  = '{1'b0, 32'h0001_0005, 32'h0,        4'h0, 1'b1,   1'b0,   32'hDEADBEEF};
        vecs[1]  = '{1'b0, 32'h0001_0030, 32'h0,        4'h0, 1'b1,   1'b0,   32'h12345678};
        vecs[2]  = '{1'b1, 32'h0001_0020, 32'h11223344, 4'h5, WR_EN,  !WR_EN, 32'h12345678};
        vecs[3]  = '{1'b0, 32'h0001_0020, 32'h0,        4'h0, 1'b1,   1'b0,   bw_exp};
        vecs[4]  = '{1'b0, 32'h0002_0000, 32'h0,        4'h0, 1'b0,   1'b1,   bw_exp};
        vecs[5]  = '{1'b1, 32'h0001_0030, 32'hFFFFFFFF, 4'h0, WR_EN,  !WR_EN, bw_exp};
        vecs[6]  = '{1'b0, 32'h0001_0030, 32'h0,        4'h0, 1'b1,   1'b0,   32'h12345678};
        vecs[7]  = '{1'b1, 32'h0002_0030, 32'h0,        4'hF, 1'b0,   1'b1,   32'h12345678};
        vecs[8]  = '{1'b0, 32'h0001_0030, 32'h0,        4'h0, 1'b1,   1'b0,   32'h12345678};
        vecs[9]  = '{1'b1, 32'h0001_0040, 32'h0BADF00D, 4'hF, WR_EN,  !WR_EN, 32'h12345678};
        vecs[10] = '{1'b0, 32'h0001_0040, 32'h0,        4'h0, 1'b1,   1'b0,   fw_exp};
        vecs[11] = '{1'b0, 32'h0001_0FFF, 32'h0,        4'h0, 1'b1,   1'b0,   32'hCAFEF00D};
        vecs[12] = '{1'b0, 32'h0000_0FFF, 32'h0,        4'h0, 1'b0,   1'b1,   32'hCAFEF00D};
        vecs[13] = '{1'b0, 32'hFFFF_0005, 32'h0,        4'h0, 1'b0,   1'b1,   32'hCAFEF00D};

        repeat (2) @(negedge clk);
        chk("reset ack", 32'(ack), 32'd0);
        chk("reset err", 32'(err), 32'd0);
        chk("reset stall", 32'(stall), 32'd0);
        chk("reset data", rdat, 32'd0);
        chk("reset stall_t", 32'(stall_t), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Burst of 8 reads, one per clock.
        ack_pat = '0; err_pat = '0; stall_pat = '0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = A_BASE + 32'h10;
        for (int j = 0; j < 14; j++) begin
            @(negedge clk);
            stall_pat[j] = stall; ack_pat[j] = ack; err_pat[j] = err; cap_dat[j] = rdat;
            @(posedge clk); #1;
            if (j + 1 < 8) addr = A_BASE + 32'h10 + 32'(j + 1);
            else stb = 1'b0;
        end
        chk("burst stall", 32'(stall_pat), 32'h0);
        chk("burst ack", 32'(ack_pat), 32'h03FC);
        chk("burst err", 32'(err_pat), 32'h0);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("burst data%0d", i), cap_dat[i + 2], 32'hB000_0000 + 32'(i));
        end

        // Throttle on the MAXOUT=1 instance: accept every other cycle.
        ack_pat = '0; stall_pat = '0; acc_pat = '0; na = 0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b0; stb_t = 1'b1; we = 1'b0; addr = A_BASE + 32'h10;
        for (int j = 0; j < 12; j++) begin
            @(negedge clk);
            stall_pat[j] = stall_t; ack_pat[j] = ack_t; cap_dat[j] = rdat_t;
            acc = stb_t && !stall_t;
            acc_pat[j] = acc;
            @(posedge clk); #1;
            if (acc) begin
                na++;
                if (na < 4) addr = A_BASE + 32'h10 + 32'(na);
                else stb_t = 1'b0;
            end
        end
        chk("throttle accepts", 32'(acc_pat), 32'h0055);
        chk("throttle stall", 32'(stall_pat), 32'h00AA);
        chk("throttle ack", 32'(ack_pat), 32'h0154);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("throttle data%0d", i), cap_dat[2 + 2*i], 32'hB000_0000 + 32'(i));
        end

        // Abort: two reads, CYC low for one cycle (STB high, must be ignored), then a fresh read.
        ack_pat = '0; err_pat = '0; stall_pat = '0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = A_BASE + 32'h05;
        for (int j = 0; j < 8; j++) begin
            @(negedge clk);
            stall_pat[j] = stall; ack_pat[j] = ack; err_pat[j] = err; cap_dat[j] = rdat;
            @(posedge clk); #1;
            case (j)
                0: addr = A_BASE + 32'h30;
                1: begin cyc = 1'b0; stb = 1'b1; addr = A_BASE + 32'h12; end
                2: begin cyc = 1'b1; stb = 1'b1; addr = A_BASE + 32'h11; end
                3: stb = 1'b0;
                default: ;
            endcase
        end
        chk("abort ack", 32'(ack_pat & 16'h00F8), 32'h0020);
        chk("abort err", 32'(err_pat & 16'h00F8), 32'h0);
        chk("abort stall", 32'(stall_pat & 16'h00F8), 32'h0);
        chk("abort data", cap_dat[5], 32'hB000_0001);

        // Write immediately followed by read of the same word.
        ack_pat = '0; err_pat = '0;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; addr = A_BASE + 32'h50; wdat = 32'h55667788; sel = 4'hF;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            ack_pat[j] = ack; err_pat[j] = err; cap_dat[j] = rdat;
            @(posedge clk); #1;
            if (j == 0) we = 1'b0;
            if (j == 1) stb = 1'b0;
        end
        chk("wr_rd ack", 32'(ack_pat & 16'h003F), WR_EN ? 32'h000C : 32'h0008);
        chk("wr_rd err", 32'(err_pat & 16'h003F), WR_EN ? 32'h0 : 32'h0004);
        chk("wr_rd data", cap_dat[3], WR_EN ? 32'h55667788 : 32'h50505050);

        // Asynchronous reset in the middle of a burst.
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; addr = A_BASE + 32'h10;
        for (int j = 0; j < 3; j++) begin
            @(posedge clk); #1;
            addr = A_BASE + 32'h11 + 32'(j);
        end
        #2;
        chk("pre-reset ack", 32'(ack), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid-reset ack", 32'(ack), 32'd0);
        chk("mid-reset err", 32'(err), 32'd0);
        chk("mid-reset stall", 32'(stall), 32'd0);
        chk("mid-reset data", rdat, 32'd0);
        cyc = 1'b0; stb = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec('{1'b0, 32'h0001_0030, 32'h0, 4'h0, 1'b1, 1'b0, 32'h12345678}, "post-reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/wb_imem_slave.md
Name: wb_imem_slave

Overview:
- Pipelined Wishbone (B4 pipelined, classic-compatible) responder backed by on-chip synchronous RAM.
- Serves the CPU instruction-fetch master and any other bus master that reads program/data memory.
- Fixed-latency, in-order ack/err responses; bounded outstanding requests via o_wb_stall; clean abort when the master drops CYC.

Parameters:
- ADDRESS_WIDTH, 32: word-address width of the bus (o_wb_addr width on the master side).
- MEMW, 12: log2 of memory depth in 32-bit words (4096 words).
- BASE, 32'h0001_0000: word base address; only bits [ADDRESS_WIDTH-1:MEMW] are compared.
- LAT, 2: request-to-response latency in clocks, legal 1..4.
- MAXOUT, 2: maximum outstanding requests, legal 1..LAT.

Ports:
- i_clk  in  1  clock, all logic on rising edge.
- i_rst_n  in  1  asynchronous active-low reset.
- i_wb_cyc  in  1  bus cycle active.
- i_wb_stb  in  1  request strobe.
- i_wb_we  in  1  1 = write, 0 = read.
- i_wb_addr  in  ADDRESS_WIDTH  word address.
- i_wb_data  in  32  write data.
- i_wb_sel  in  4  byte-lane enables; bit n covers data[8n+7:8n].
- o_wb_stall  out  1  request not accepted this cycle.
- o_wb_ack  out  1  successful response.
- o_wb_err  out  1  error response.
- o_wb_data  out  32  read data, valid only while o_wb_ack=1 for a read.

Behaviour:
- Reset: async assert on i_rst_n low, synchronous release. o_wb_ack=0, o_wb_err=0, o_wb_stall=0, o_wb_data=0, outstanding count=0, response pipeline tags cleared. RAM contents are not reset.
- Accept: a request is accepted when i_wb_cyc && i_wb_stb && !o_wb_stall. STB with CYC low is ignored.
- In-range test: i_wb_addr[ADDRESS_WIDTH-1:MEMW] == BASE[ADDRESS_WIDTH-1:MEMW]. RAM index is i_wb_addr[MEMW-1:0].
- Response timing: every accepted request gets exactly one response, exactly LAT cycles after the accept edge, in order. The response is ack for in-range requests and err for out-of-range; ack and err are never both high.
- Response pipeline: LAT-deep shift register of {valid, err, we} tags. Read data travels alongside the tags; the RAM read occurs at the accept edge, and stages beyond the first carry the data forward.
- Writes: committed to RAM at the accept edge, only for lanes with sel set. sel=0 commits nothing but is still acked. Out-of-range writes are not committed and get err.
- Write-then-read: a read accepted on the cycle after a write to the same address returns the new data.
- o_wb_data: updates only on read acks; holds its previous value otherwise (writes and errs included).
- Outstanding counter (width clog2(MAXOUT+1)):
  - +1 on accept, -1 on response; both in one cycle leaves it unchanged.
  - o_wb_stall = (count == MAXOUT) && !(response this cycle), computed combinationally from registered state.
- Abort: i_wb_cyc low for any cycle clears all tags and the counter at the next edge. No ack/err is issued for requests accepted before the abort; any response already on the outputs that cycle is dropped on the following edge. Writes already accepted remain committed.
- Reset mid-operation: same clearing as abort, plus outputs forced to reset values immediately.
- Back-to-back: with MAXOUT=LAT, one request per clock is sustained indefinitely with no stall.

Optional Feature:
- Macro IMEM_WRITE_EN.
- Defined: writes behave as above.
- Undefined: the memory is read-only. Every accepted write gets err at latency LAT, RAM is never written, and the RAM write port and i_wb_sel/i_wb_data logic are removed. Reads are unchanged.

Decomposition:
- Shared package wb_imem_pkg:
  - response-tag typedef {valid, err, we};
  - LAT_MIN=1 and LAT_MAX=4 constants;
  - clog2 function used for counter width.
- Sub-module wb_imem_ram: single-port synchronous RAM (depth 2^MEMW x 32) with per-byte write enable and registered read. It isolates vendor BRAM inference; the top block holds the counter, tags, stall and abort logic.

Test Plan:
- Single read, LAT=2: preload word 0x005 = 0xDEADBEEF; read addr 0x0001_0005 accepted at cycle t -> ack=1 with data 0xDEADBEEF at t+2, err=0, exactly one ack.
- Burst, MAXOUT=LAT=2: 8 consecutive reads of addrs 0x0001_0000..7 -> stall never asserts; acks on 8 consecutive cycles starting 2 cycles after the first accept; data returned in address order.
- Throttle, MAXOUT=1, LAT=2: STB held high for 4 reads -> stall high on the cycle after each accept until its ack; one accept every 2 cycles; 4 acks total.
- Byte write: write 0x11223344 sel=4'b0101 to a word holding 0xAAAAAAAA, then read -> 0xAA22AA44. Without IMEM_WRITE_EN: err at LAT, and a subsequent read returns 0xAAAAAAAA.
- Out of range: read 0x0002_0000 -> err at t+LAT, ack=0, o_wb_data unchanged.
- Abort: accept 2 reads, drop cyc the next cycle -> zero ack/err afterwards, counter 0, stall 0; a new cycle one clock later is accepted and acked normally.
- Async reset during burst: pull i_rst_n low between edges -> ack/err/stall low immediately; after release, first read acks at LAT with correct data.
